// File: rtl/memory_responder_pkg.sv
// memory_responder_pkg: shared types and constants for the memory responder and its boot loader
package memory_responder_pkg;
    typedef enum logic [1:0] {LOAD, DONE, RUN} loader_state_t;
    localparam logic [31:0] NOP_INSN = 32'h00000013;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/memory_responder_boot_loader.sv
// boot_loader: packs a little-endian byte stream into imem words and holds the core in reset until the image is in
module boot_loader
    import memory_responder_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    localparam int AW = $clog2(IMEM_WORDS),
    localparam int PW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [7:0]    load_byte,
    input  logic          load_last,
    input  logic          reload,
    output logic          load_ready,
    output logic          core_reset,
    output logic          load_error,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata
);
    loader_state_t state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [31:0]   asm_q, asm_d, packed_word;
    logic          err_q, err_d, accept, word_done, full;

    always_comb begin
        packed_word = asm_q | ({24'b0, load_byte} << {bcnt_q, 3'b000});
        full = ptr_q == PW'(IMEM_WORDS);
        accept = load_valid && state_q == LOAD;
        word_done = accept && (bcnt_q == 2'(BYTES_PER_WORD - 1) || load_last);
        state_d = state_q;
        ptr_d = ptr_q;
        bcnt_d = bcnt_q;
        asm_d = asm_q;
        err_d = err_q | (accept && full);
        if (accept) begin
            bcnt_d = word_done ? 2'd0 : bcnt_q + 2'd1;
            asm_d = word_done ? '0 : packed_word;
            ptr_d = (word_done && !full) ? ptr_q + PW'(1) : ptr_q;
            if (load_last) state_d = DONE;
        end
        if (state_q == DONE) state_d = RUN;
        if (state_q == RUN && reload) begin
            state_d = LOAD;
            ptr_d = '0;
            bcnt_d = '0;
            asm_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            ptr_q <= '0;
            bcnt_q <= '0;
            asm_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            bcnt_q <= bcnt_d;
            asm_q <= asm_d;
            err_q <= err_d;
        end
    end

    assign load_ready = state_q == LOAD;
    assign core_reset = state_q != RUN;
    assign load_error = err_q;
    assign imem_we = word_done && !full;
    assign imem_waddr = ptr_q[AW-1:0];
    assign imem_wdata = packed_word;
endmodule

// File: rtl/memory_responder.sv
// memory_responder: dual-word instruction fetch, combinational-read data memory and boot loader for the core
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic [31:0] Ins1,
    output logic [31:0] Ins2,
    input  logic [31:0] ALUResult1,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    input  logic        load_last,
    output logic        load_ready,
    input  logic        reload,
    output logic        core_reset,
    output logic        load_error
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0]    imem [IMEM_WORDS];
    logic [31:0]    dmem [DMEM_WORDS];
    logic           imem_we;
    logic [IAW-1:0] imem_waddr, i_idx, i_nxt;
    logic [31:0]    imem_wdata;
    logic [DAW-1:0] d_idx;
    logic           unused_bits;

    boot_loader #(.IMEM_WORDS(IMEM_WORDS)) u_loader (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_last  (load_last),
        .reload     (reload),
        .load_ready (load_ready),
        .core_reset (core_reset),
        .load_error (load_error),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata)
    );

    // Index arithmetic is IAW/DAW bits wide, so fetch and data addresses wrap for free
    always_comb begin
        i_idx = PC[IAW+1:2];
        i_nxt = i_idx + IAW'(1);
        d_idx = ALUResult1[DAW+1:2];
        Ins1 = core_reset ? NOP_INSN : imem[i_idx];
        Ins2 = core_reset ? NOP_INSN : imem[i_nxt];
        ReadData = dmem[d_idx];
    end

    assign unused_bits = ^{PC[31:IAW+2], PC[1:0], ALUResult1[31:DAW+2], ALUResult1[1:0]};

    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_waddr] <= imem_wdata;
        if (MemWrite && !core_reset) dmem[d_idx] <= WriteData;
    end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: scoreboard bench for the default and a 4-word-imem memory_responder
module tb_memory_responder;
    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] PC = '0, ALUResult1 = '0, WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        load_valid = 1'b0, load_last = 1'b0, reload = 1'b0;
    logic [7:0]  load_byte = '0;
    logic        s_valid = 1'b0, s_last = 1'b0, s_reload = 1'b0;
    logic [7:0]  s_byte = '0;
    logic [31:0] Ins1, Ins2, ReadData, s_ins1, s_ins2, s_rd;
    logic        load_ready, core_reset, load_error, s_ready, s_crst, s_err;
    int          checks = 0, failures = 0;
    exp_t        sb [$];

    always #5 clk = ~clk;

    memory_responder dut (
        .clk(clk), .reset(reset), .PC(PC), .Ins1(Ins1), .Ins2(Ins2),
        .ALUResult1(ALUResult1), .WriteData(WriteData), .MemWrite(MemWrite), .ReadData(ReadData),
        .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready),
        .reload(reload), .core_reset(core_reset), .load_error(load_error)
    );

    memory_responder #(.IMEM_WORDS(4), .DMEM_WORDS(16)) dut_s (
        .clk(clk), .reset(reset), .PC(PC), .Ins1(s_ins1), .Ins2(s_ins2),
        .ALUResult1(ALUResult1), .WriteData(WriteData), .MemWrite(MemWrite), .ReadData(s_rd),
        .load_valid(s_valid), .load_byte(s_byte), .load_last(s_last), .load_ready(s_ready),
        .reload(s_reload), .core_reset(s_crst), .load_error(s_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic pop(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", got, 32'hxxxx_xxxx);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sm, input logic [7:0] b, input bit last);
        if (sm) begin s_valid = 1'b1; s_byte = b; s_last = last; end
        else begin load_valid = 1'b1; load_byte = b; load_last = last; end
        tick();
        s_valid = 1'b0; s_last = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    endtask

    initial begin
        logic [7:0] img1 [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        logic [7:0] img2 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        tick();
        tick();
        reset = 1'b0;
        push("rst_core_reset", 1); pop(core_reset);
        push("rst_load_ready", 1); pop(load_ready);
        push("rst_load_error", 0); pop(load_error);
        push("rst_ins1", 32'h13);  pop(Ins1);
        push("rst_ins2", 32'h13);  pop(Ins2);

        for (int i = 0; i < 8; i++) send(0, img1[i], i == 7);
        push("done_core_reset", 1); pop(core_reset);
        push("done_ready", 0);      pop(load_ready);
        tick();
        push("run_core_reset", 0);  pop(core_reset);
        PC = 0; #1;
        push("img1_ins1", 32'h00100513); pop(Ins1);
        push("img1_ins2", 32'h00200593); pop(Ins2);

        ALUResult1 = 32'h10; WriteData = 32'hCAFEF00D; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        push("dmem_rd", 32'hCAFEF00D); pop(ReadData);
        ALUResult1 = 32'h410; #1;
        push("dmem_alias", 32'hCAFEF00D); pop(ReadData);

        ALUResult1 = 32'h20; WriteData = 32'h11112222; MemWrite = 1'b1; reload = 1'b1;
        tick();
        MemWrite = 1'b0; reload = 1'b0;
        push("wr_on_reload", 32'h11112222); pop(ReadData);
        push("reload_core_reset", 1); pop(core_reset);
        push("reload_ready", 1);      pop(load_ready);
        push("reload_ins1_nop", 32'h13); pop(Ins1);
        ALUResult1 = 32'h10; WriteData = 32'hDEADBEEF; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        push("wr_in_load", 32'hCAFEF00D); pop(ReadData);

        for (int i = 0; i < 5; i++) send(0, img2[i], i == 4);
        tick();
        PC = 32'h4; #1;
        push("img2_ins1", 32'h000000EE); pop(Ins1);
        PC = 32'h3FC; #1;
        push("img2_wrap_ins2", 32'hDDCCBBAA); pop(Ins2);

        reload = 1'b1; tick(); reload = 1'b0;
        for (int i = 1; i <= 6; i++) send(0, 8'(i), 0);
        reset = 1'b1; tick(); reset = 1'b0;
        push("midrst_ready", 1); pop(load_ready);
        send(0, 8'h11, 0); send(0, 8'h22, 0); send(0, 8'h33, 0); send(0, 8'h44, 1);
        tick();
        PC = 0; #1;
        push("midrst_ins1", 32'h44332211); pop(Ins1);
        push("midrst_ins2", 32'h000000EE); pop(Ins2);

        for (int i = 1; i <= 20; i++) begin
            send(1, 8'(i), i == 20);
            if (i == 16) begin push("ovf_err16", 0); pop(s_err); end
            if (i == 17) begin push("ovf_err17", 1); pop(s_err); end
            if (i == 19) begin push("ovf_ready19", 1); pop(s_ready); end
        end
        push("ovf_ready_last", 0); pop(s_ready);
        tick();
        PC = 0; #1;
        push("ovf_w0", 32'h04030201); pop(s_ins1);
        push("ovf_w1", 32'h08070605); pop(s_ins2);
        PC = 32'h8; #1;
        push("ovf_w2", 32'h0C0B0A09); pop(s_ins1);
        push("ovf_w3", 32'h100F0E0D); pop(s_ins2);
        s_reload = 1'b1; tick(); s_reload = 1'b0;
        push("ovf_err_reload", 1); pop(s_err);
        push("ovf_crst_reload", 1); pop(s_crst);
        reset = 1'b1; tick(); reset = 1'b0;
        push("ovf_err_reset", 0); pop(s_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
